// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes the
// assembled 32-bit words into instruction memory and releases the core on success.
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_wen,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_nrst,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERROR
    } state_e;

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]       CAPACITY  = 17'(1) << ADDR_WIDTH;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            acc_q, acc_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_nrst_q, cpu_nrst_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic        xfer;
    logic [15:0] n_full;
    logic [16:0] word_next;

    assign in_ready  = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                       (state_q == DATA)   || (state_q == CHK);
    assign xfer      = in_valid && in_ready;
    assign n_full    = {in_data, n_q[7:0]};
    assign word_next = word_cnt_q + 17'd1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        acc_d      = acc_q;
        idle_d     = idle_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_nrst_d = cpu_nrst_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = HDR_LO;
                    n_d        = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    acc_d      = '0;
                    idle_d     = '0;
                    cpu_nrst_d = 1'b0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                end else if (state_q == DONE) begin
                    // Core is released one cycle after DONE is entered.
                    cpu_nrst_d = 1'b1;
                end
            end
            default: begin
                if (xfer) begin
                    idle_d = '0;
                    acc_d  = acc_q ^ in_data;
                    case (state_q)
                        HDR_LO: begin
                            n_d[7:0] = in_data;
                            state_d  = HDR_HI;
                        end
                        HDR_HI: begin
                            n_d = n_full;
                            if ({1'b0, n_full} > CAPACITY) begin
                                state_d    = ERROR;
                                error_d    = 1'b1;
                                err_code_d = 2'b01;
                            end else if (n_full == 16'd0) begin
                                state_d = CHK;
                            end else begin
                                state_d = DATA;
                            end
                        end
                        DATA: begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            asm_d      = {in_data, asm_q[23:8]};
                            if (byte_cnt_q == 2'd3) begin
                                wen_d      = 1'b1;
                                waddr_d    = word_cnt_q[ADDR_WIDTH-1:0];
                                wdata_d    = {in_data, asm_q};
                                word_cnt_d = word_next;
                                if (word_next == {1'b0, n_q}) state_d = CHK;
                            end
                        end
                        default: begin
                            if (in_data == acc_q) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d    = ERROR;
                                error_d    = 1'b1;
                                err_code_d = 2'b10;
                            end
                        end
                    endcase
                end else if (idle_q == IDLE_LAST) begin
                    state_d    = ERROR;
                    error_d    = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            acc_q      <= '0;
            idle_q     <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_nrst_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            acc_q      <= acc_d;
            idle_q     <= idle_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_nrst_q <= cpu_nrst_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign imem_wen   = wen_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_nrst   = cpu_nrst_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule
